byte_frame_parser: RTL and testbench
====================================

Name: byte_frame_parser

Overview:
Downstream consumer of the 8-bit registered byte lane, which updates on the falling clock edge and idles at 0x34 in reset. It parses framed packets from that lane: SOF, length, payload, then checksum. Payload bytes are forwarded as a stream with a last marker. Each frame ends with a one-cycle ok or error pulse.

Parameters:
IDLE_BYTE, 8'h34, idle/fill pattern; silently ignored outside a frame
SOF_BYTE, 8'hA5, start-of-frame marker
MAX_LEN, 16, largest legal payload length (1..255)
TIMEOUT, 8, maximum consecutive in_valid-low cycles tolerated mid-frame

Ports:
clk  input  1  clock; all state updates on the falling edge
reset  input  1  synchronous, active-high
in_valid  input  1  in_data qualifier
in_data  input  8  byte from the upstream register
out_valid  output  1  payload byte valid
out_data  output  8  payload byte
out_last  output  1  high with the final payload byte of a frame
frame_ok  output  1  one-cycle pulse: checksum matched
frame_err  output  1  one-cycle pulse: frame aborted or bad
err_code  output  2  valid with frame_err: 1=bad length, 2=bad checksum, 3=timeout; 0 otherwise

Behaviour:
- Reset: reset, synchronous, active-high. Sampled on the falling clk edge. State goes to IDLE. All outputs, the length register, the byte counter, the sum and the timeout counter clear to 0. Reset has priority over every other event.
- Reset mid-frame: the frame is abandoned. No frame_err and no further out_valid are produced.
- All outputs are registered. Each response appears on the falling edge that samples the causing byte and holds for one clk period.
- IDLE state:
  - in_valid && in_data==SOF_BYTE moves to LEN.
  - All other bytes are dropped, including IDLE_BYTE. No output is produced.
- LEN state, on a valid byte:
  - Byte is 0 or greater than MAX_LEN: pulse frame_err with err_code=1, return to IDLE.
  - Otherwise: store the length, set sum=length, set count=0, move to PAYLOAD.
- PAYLOAD state, on each valid byte:
  - Assert out_valid with out_data=byte.
  - sum = (sum + byte) mod 256.
  - When count==len-1: assert out_last and move to CHK. Otherwise increment count.
  - Payload may contain any value, including SOF_BYTE and IDLE_BYTE. These are not interpreted.
- CHK state, on a valid byte:
  - byte==sum: pulse frame_ok.
  - Otherwise: pulse frame_err with err_code=2.
  - Return to IDLE in both cases.
- Back-to-back frames: a SOF on the cycle immediately after the checksum byte is accepted.
- Timeout (LEN, PAYLOAD and CHK only):
  - The counter increments on each in_valid-low cycle and clears on each in_valid-high cycle.
  - When it reaches TIMEOUT: pulse frame_err with err_code=3, return to IDLE.
  - out_last is never emitted for a frame that times out.
- in_valid low pauses parsing without loss. out_valid stays low during gaps.
- Length and count registers are 8 bits wide. The sum is 8 bits and wraps.

Decomposition:
- Shared package holds:
  - state enum: IDLE, LEN, PAYLOAD, CHK
  - err_code constants: ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2, ERR_TMO=3
  - default constants IDLE_BYTE and SOF_BYTE
- One sub-module, frame_timeout_ctr, is natural: a parameterised gap counter with a clear input and an expire pulse output.
- The FSM, counter and checksum stay in the top module.

Test Plan:
- Idle stream: 20 cycles of 0x34 with in_valid=1 -> no out_valid, no frame_ok, no frame_err.
- Good frame: A5 03 10 20 30 63 -> out_data 10, 20, 30 with out_valid; out_last only with 30; frame_ok one cycle, on the edge sampling 63; err_code=0.
- Bad checksum: A5 03 10 20 30 64 -> three payload bytes forwarded; frame_err with err_code=2; frame_ok stays 0.
- Bad length: A5 00, then A5 11 (17 > MAX_LEN) -> frame_err with err_code=1 after each length byte; no out_valid.
- Timeout and gap: A5 02 40, then in_valid low for 3 cycles, then 50 72 -> frame_ok, output unaffected by the gap. Then A5 02 40 followed by 8 low cycles -> frame_err with err_code=3 on the 8th low cycle.
- Reset mid-frame: A5 04 01, assert reset for one cycle, then send A5 01 07 08 -> no error pulse from the aborted frame; new frame yields out_data=07 with out_last, then frame_ok.

Source files
------------

// File: rtl/byte_frame_parser_pkg.sv
// Shared types and constants for the byte frame parser.
package byte_frame_parser_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] IDLE_BYTE_DFLT = 8'h34;
    localparam logic [7:0] SOF_BYTE_DFLT  = 8'hA5;

endpackage

// File: rtl/frame_timeout_ctr.sv
// Counts consecutive gap cycles; expire fires combinationally on the cycle
// that would bring the count to TIMEOUT, so the parent can register it.
module frame_timeout_ctr #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic gap,
    output logic expire
);

    logic [7:0] count;

    assign expire = !clear && gap && (count == 8'(TIMEOUT - 1));

    // Gap counter: restarts on clear or on expiry, otherwise advances per gap cycle.
    always_ff @(negedge clk) begin
        if (reset || clear || expire) begin
            count <= 8'd0;
        end else if (gap) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/byte_frame_parser.sv
// Parses SOF / length / payload / checksum frames from a falling-edge byte
// lane, forwarding payload bytes and ending each frame with an ok/err pulse.
module byte_frame_parser
    import byte_frame_parser_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DFLT,
    parameter logic [7:0] SOF_BYTE  = SOF_BYTE_DFLT,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    state_t     state, state_nx;
    logic [7:0] len, len_nx;
    logic [7:0] cnt, cnt_nx;
    logic [7:0] sum, sum_nx;
    logic       out_valid_nx, out_last_nx, frame_ok_nx, frame_err_nx;
    logic [7:0] out_data_nx;
    logic [1:0] err_code_nx;
    logic       tmo_clear, tmo_expire;

    // The gap counter only runs while a frame is in progress.
    assign tmo_clear = (state == IDLE) || in_valid;

    frame_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmo_clear),
        .gap    (!in_valid),
        .expire (tmo_expire)
    );

    // Next-state and next-output decode; every output is a one-cycle response.
    always_comb begin
        state_nx     = state;
        len_nx       = len;
        cnt_nx       = cnt;
        sum_nx       = sum;
        out_valid_nx = 1'b0;
        out_data_nx  = 8'd0;
        out_last_nx  = 1'b0;
        frame_ok_nx  = 1'b0;
        frame_err_nx = 1'b0;
        err_code_nx  = ERR_NONE;
        if (tmo_expire) begin
            frame_err_nx = 1'b1;
            err_code_nx  = ERR_TMO;
            state_nx     = IDLE;
        end else if (in_valid) begin
            case (state)
                IDLE: begin
                    if (in_data == SOF_BYTE) begin
                        state_nx = LEN;
                    end else if (in_data == IDLE_BYTE) begin
                        // Fill is dropped like any other stray byte.
                        state_nx = IDLE;
                    end
                end
                LEN: begin
                    if (in_data == 8'd0 || in_data > 8'(MAX_LEN)) begin
                        frame_err_nx = 1'b1;
                        err_code_nx  = ERR_LEN;
                        state_nx     = IDLE;
                    end else begin
                        len_nx   = in_data;
                        sum_nx   = in_data;
                        cnt_nx   = 8'd0;
                        state_nx = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    out_valid_nx = 1'b1;
                    out_data_nx  = in_data;
                    sum_nx       = sum + in_data;
                    if (cnt == len - 8'd1) begin
                        out_last_nx = 1'b1;
                        state_nx    = CHK;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
                CHK: begin
                    if (in_data == sum) begin
                        frame_ok_nx = 1'b1;
                    end else begin
                        frame_err_nx = 1'b1;
                        err_code_nx  = ERR_CSUM;
                    end
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State, datapath and output registers, all cleared by reset.
    always_ff @(negedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len       <= 8'd0;
            cnt       <= 8'd0;
            sum       <= 8'd0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state     <= state_nx;
            len       <= len_nx;
            cnt       <= cnt_nx;
            sum       <= sum_nx;
            out_valid <= out_valid_nx;
            out_data  <= out_data_nx;
            out_last  <= out_last_nx;
            frame_ok  <= frame_ok_nx;
            frame_err <= frame_err_nx;
            err_code  <= err_code_nx;
        end
    end

endmodule

// File: tb/tb_byte_frame_parser.sv
// Bench for byte_frame_parser: stimulus and expected per-cycle responses are
// built together at frame level, then replayed and compared cycle by cycle.
module tb_byte_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [7:0] data;
    } stim_t;

    typedef struct packed {
        logic       ov;
        logic [7:0] od;
        logic       ol;
        logic       ok;
        logic       err;
        logic [1:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h34;
    logic       out_valid, out_last, frame_ok, frame_err;
    logic [7:0] out_data;
    logic [1:0] err_code;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    cur = 0;
    bit    chk_en = 1'b0;
    bit    done = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;
    exp_t  e_cur;

    byte_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic put(input logic r, input logic v, input logic [7:0] d,
                       input logic ov, input logic [7:0] od, input logic ol,
                       input logic ok, input logic err, input logic [1:0] code);
        stim_t s;
        exp_t  e;
        s.rst = r; s.vld = v; s.data = d;
        e.ov = ov; e.od = od; e.ol = ol; e.ok = ok; e.err = err; e.code = code;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic quiet(input logic r, input logic v, input logic [7:0] d);
        put(r, v, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) quiet(1'b0, 1'b0, 8'($urandom));
    endtask

    // Short pauses inside a frame never reach the timeout.
    task automatic rand_gap();
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, TIMEOUT - 1));
    endtask

    task automatic idle_fill(input int n);
        for (int i = 0; i < n; i++) begin
            logic       v;
            logic [7:0] d;
            v = 1'($urandom);
            d = ($urandom_range(0, 1) == 0) ? 8'h34 : 8'($urandom);
            if (v && d == 8'hA5) d = 8'h34;
            quiet(1'b0, v, d);
        end
    endtask

    task automatic payload(input int n, input int len, inout logic [7:0] s);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            rand_gap();
            b = 8'($urandom);
            s = s + b;
            put(1'b0, 1'b1, b, 1'b1, b, (i == len - 1), 1'b0, 1'b0, 2'd0);
        end
    endtask

    task automatic rand_frame(input bit corrupt);
        int         len;
        logic [7:0] s, c;
        len = $urandom_range(1, MAX_LEN);
        s = 8'(len);
        quiet(1'b0, 1'b1, 8'hA5);
        rand_gap();
        quiet(1'b0, 1'b1, 8'(len));
        payload(len, len, s);
        rand_gap();
        c = corrupt ? s + 8'($urandom_range(1, 255)) : s;
        put(1'b0, 1'b1, c, 1'b0, 8'h00, 1'b0, !corrupt, corrupt, corrupt ? 2'd2 : 2'd0);
    endtask

    task automatic rand_bad_len();
        logic [7:0] l;
        l = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
        quiet(1'b0, 1'b1, 8'hA5);
        rand_gap();
        put(1'b0, 1'b1, l, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1);
    endtask

    task automatic rand_timeout();
        int         len;
        logic [7:0] s;
        quiet(1'b0, 1'b1, 8'hA5);
        if ($urandom_range(0, 1) == 1) begin
            len = $urandom_range(1, MAX_LEN);
            s = 8'(len);
            quiet(1'b0, 1'b1, 8'(len));
            payload($urandom_range(0, len - 1), len, s);
        end
        gap(TIMEOUT - 1);
        put(1'b0, 1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3);
    endtask

    task automatic rand_reset_abort();
        int         len;
        logic [7:0] s;
        len = $urandom_range(1, MAX_LEN);
        s = 8'(len);
        quiet(1'b0, 1'b1, 8'hA5);
        quiet(1'b0, 1'b1, 8'(len));
        payload($urandom_range(0, len - 1), len, s);
        quiet(1'b1, 1'($urandom), 8'($urandom));
    endtask

    // Compare process: outputs settle on the falling edge, checked 1 time unit later.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            e_cur = exp_q[cur];
            vectors++;
            if (out_valid !== e_cur.ov || (e_cur.ov && out_data !== e_cur.od) ||
                out_last !== e_cur.ol || frame_ok !== e_cur.ok ||
                frame_err !== e_cur.err || err_code !== e_cur.code) begin
                miscompares++;
                $display("FAIL cycle %0d: got v=%b d=%h last=%b ok=%b err=%b code=%0d, expected v=%b d=%h last=%b ok=%b err=%b code=%0d",
                         cur, out_valid, out_data, out_last, frame_ok, frame_err, err_code,
                         e_cur.ov, e_cur.od, e_cur.ol, e_cur.ok, e_cur.err, e_cur.code);
            end
        end
    end

    // Watchdog: the replay must finish within a bounded time.
    initial begin
        #20_000_000;
        if (!done) begin
            miscompares++;
            $display("FAIL: wait for end of replay expired after %0t", $time);
            $finish;
        end
    end

    initial begin
        // Reset state.
        for (int i = 0; i < 3; i++) quiet(1'b1, 1'b0, 8'h34);
        // Idle stream.
        for (int i = 0; i < 20; i++) quiet(1'b0, 1'b1, 8'h34);
        // Good frame A5 03 10 20 30 63.
        quiet(1'b0, 1'b1, 8'hA5);
        quiet(1'b0, 1'b1, 8'h03);
        put(1'b0, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 2'd0);
        put(1'b0, 1'b1, 8'h20, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 2'd0);
        put(1'b0, 1'b1, 8'h30, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 2'd0);
        put(1'b0, 1'b1, 8'h63, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        // Bad checksum, back to back.
        quiet(1'b0, 1'b1, 8'hA5);
        quiet(1'b0, 1'b1, 8'h03);
        put(1'b0, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 2'd0);
        put(1'b0, 1'b1, 8'h20, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 2'd0);
        put(1'b0, 1'b1, 8'h30, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 2'd0);
        put(1'b0, 1'b1, 8'h64, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2);
        // Bad lengths 0 and 17.
        quiet(1'b0, 1'b1, 8'hA5);
        put(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1);
        quiet(1'b0, 1'b1, 8'hA5);
        put(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1);
        // Longest legal length on the boundary: 16 zero bytes, checksum 0x10.
        quiet(1'b0, 1'b1, 8'hA5);
        quiet(1'b0, 1'b1, 8'h10);
        for (int i = 0; i < 16; i++)
            put(1'b0, 1'b1, 8'h00, 1'b1, 8'h00, (i == 15), 1'b0, 1'b0, 2'd0);
        put(1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        // Gap of 3 mid-frame: 02+40+50 = 92.
        quiet(1'b0, 1'b1, 8'hA5);
        quiet(1'b0, 1'b1, 8'h02);
        put(1'b0, 1'b1, 8'h40, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 2'd0);
        quiet(1'b0, 1'b0, 8'hA5);
        quiet(1'b0, 1'b0, 8'h34);
        quiet(1'b0, 1'b0, 8'h00);
        put(1'b0, 1'b1, 8'h50, 1'b1, 8'h50, 1'b1, 1'b0, 1'b0, 2'd0);
        put(1'b0, 1'b1, 8'h92, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        // Timeout after 8 low cycles.
        quiet(1'b0, 1'b1, 8'hA5);
        quiet(1'b0, 1'b1, 8'h02);
        put(1'b0, 1'b1, 8'h40, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 7; i++) quiet(1'b0, 1'b0, 8'h00);
        put(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3);
        quiet(1'b0, 1'b0, 8'h00);
        // Reset mid-frame, then a fresh one-byte frame.
        quiet(1'b0, 1'b1, 8'hA5);
        quiet(1'b0, 1'b1, 8'h04);
        put(1'b0, 1'b1, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 2'd0);
        quiet(1'b1, 1'b1, 8'h02);
        quiet(1'b0, 1'b1, 8'hA5);
        quiet(1'b0, 1'b1, 8'h01);
        put(1'b0, 1'b1, 8'h07, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 2'd0);
        put(1'b0, 1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rand_frame(1'b0);
                4, 5:       rand_frame(1'b1);
                6:          rand_bad_len();
                7:          rand_timeout();
                8:          rand_reset_abort();
                default:    idle_fill($urandom_range(1, 12));
            endcase
            if ($urandom_range(0, 2) == 0) idle_fill($urandom_range(1, 4));
        end
        idle_fill(5);

        // Replay: drive on the rising edge, the DUT samples on the falling edge.
        for (int i = 0; i < stim_q.size(); i++) begin
            @(posedge clk);
            if (i == 3) begin
                if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
                    frame_ok !== 1'b0 || frame_err !== 1'b0 || err_code !== 2'd0) begin
                    miscompares++;
                    $display("FAIL reset state: v=%b d=%h last=%b ok=%b err=%b code=%0d",
                             out_valid, out_data, out_last, frame_ok, frame_err, err_code);
                end
            end
            reset    = stim_q[i].rst;
            in_valid = stim_q[i].vld;
            in_data  = stim_q[i].data;
            cur      = i;
            chk_en   = 1'b1;
        end
        @(posedge clk);
        chk_en = 1'b0;
        done   = 1'b1;
        #2;
        if (vectors != stim_q.size()) begin
            miscompares++;
            $display("FAIL: %0d vectors compared, %0d expected", vectors, stim_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares == 0) $display("PASS");
        else $display("FAIL");
        $finish;
    end

endmodule
